// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle for the shared 64-bit add/subtract unit.
// The requesters and the result consumer sit on the master side; the arbiter sits on the slave side.
interface addsub_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_a;
    logic [NUM_REQ*64-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sub;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [63:0]           resp_sum;
    logic                  resp_cout;
    logic [ID_W-1:0]       resp_id;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_cout, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_cout, resp_id
    );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Round-robin shared 64-bit add/subtract unit: one accept per cycle from NUM_REQ requesters.
// The result lands in a single valid/ready output register tagged with the owner's ID.
module addsub_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                   clk,
    input logic                   rst,
    addsub_share_arbiter_if.slave bus
);
    localparam int DATA_W = 64;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    cand;
    logic               found;
    int                 idx;
    logic               can_accept;
    logic               accept;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;
    logic [DATA_W-1:0]  b_eff;
    logic               sub_sel;
    logic [DATA_W:0]    sum_full;
    logic               vld_p0;
    logic [DATA_W-1:0]  sum_p0;
    logic               cout_p0;
    logic [ID_W-1:0]    id_p0;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
        $error("addsub_share_arbiter: NUM_REQ must be in 2..8");
    end

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found) grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel   = bus.req_a[DATA_W*i +: DATA_W];
                b_sel   = bus.req_b[DATA_W*i +: DATA_W];
                sub_sel = bus.req_sub[i];
            end
        end
    end

    // Subtract as a + ~b + 1 in 65 bits so the top bit reads as "no borrow".
    assign b_eff    = sub_sel ? ~b_sel : b_sel;
    assign sum_full = {1'b0, a_sel} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_sel};

    assign can_accept    = !vld_p0 || bus.resp_ready;
    assign accept        = found && can_accept && !rst;
    assign bus.req_ready = accept ? grant : '0;

    // Stage p0: output register, refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            sum_p0  <= '0;
            cout_p0 <= 1'b0;
            id_p0   <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            sum_p0  <= sum_full[DATA_W-1:0];
            cout_p0 <= sum_full[DATA_W];
            id_p0   <= gnt_idx;
            rr_ptr  <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (bus.resp_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign bus.resp_valid = vld_p0;
    assign bus.resp_sum   = sum_p0;
    assign bus.resp_cout  = cout_p0;
    assign bus.resp_id    = id_p0;

    a_ready_onehot0: assert property (@(posedge clk) $onehot0(bus.req_ready));

    a_resp_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.resp_valid && !bus.resp_ready) |=>
        (bus.resp_valid && $stable(bus.resp_sum) && $stable(bus.resp_cout) && $stable(bus.resp_id)));
endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Scoreboard bench for addsub_share_arbiter: per-requester op queues feed the DUT,
// a cycle model predicts grants and pushes expected results, and outputs are popped on consume.
module tb_addsub_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
    } op_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        int          id;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    addsub_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    addsub_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                 checks   = 0;
    int                 failures = 0;
    op_t                opq[NUM_REQ][$];
    res_t               sb[$];
    int                 id_log[$];
    res_t               last;
    logic [NUM_REQ-1:0] acc    = '0;
    logic               m_valid = 1'b0;
    int                 m_ptr   = 0;
    logic               mon_on  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_op(input op_t o, input int id);
        res_t        r;
        logic [64:0] w;
        if (o.sub) begin
            r.sum  = o.a - o.b;
            r.cout = (o.a >= o.b);
        end else begin
            w      = {1'b0, o.a} + {1'b0, o.b};
            r.sum  = w[63:0];
            r.cout = w[64];
        end
        r.id = id;
        return r;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (opq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a   = {$urandom, $urandom};
        o.b   = {$urandom, $urandom};
        o.sub = 1'($urandom_range(0, 1));
        if (o.b == 64'd0) o.b = 64'd1;
        return o;
    endfunction

    // Requester side: present the next queued op once the previous one is accepted.
    initial begin
        op_t o;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    if (opq[i].size() > 0) begin
                        o = opq[i].pop_front();
                        bus.req_valid[i]        = 1'b1;
                        bus.req_a[64*i +: 64]   = o.a;
                        bus.req_b[64*i +: 64]   = o.b;
                        bus.req_sub[i]          = o.sub;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Cycle model and scoreboard, evaluated between active edges.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        int                 win;
        int                 c;
        op_t                cur;
        exp_ready = '0;
        win       = -1;
        if (mon_on) begin
            if (!rst && (!m_valid || bus.resp_ready)) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && bus.req_valid[c]) win = c;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            check_eq("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    check_eq("resp_sum", bus.resp_sum, sb[0].sum);
                    check_eq("resp_cout", 64'(bus.resp_cout), 64'(sb[0].cout));
                    check_eq("resp_id", 64'(bus.resp_id), 64'(sb[0].id));
                    if (bus.resp_ready) begin
                        last.sum  = bus.resp_sum;
                        last.cout = bus.resp_cout;
                        last.id   = int'(bus.resp_id);
                        void'(sb.pop_front());
                    end
                end
            end
            if (rst) begin
                m_valid = 1'b0;
                m_ptr   = 0;
                sb.delete();
            end else if (win >= 0) begin
                cur.a   = bus.req_a[64*win +: 64];
                cur.b   = bus.req_b[64*win +: 64];
                cur.sub = bus.req_sub[win];
                sb.push_back(ref_op(cur, win));
                id_log.push_back(win);
                m_valid = 1'b1;
                m_ptr   = (win + 1) % NUM_REQ;
            end else if (bus.resp_ready) begin
                m_valid = 1'b0;
            end
        end
        acc = exp_ready;
    end

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (n < limit && !(queues_empty() && bus.req_valid == '0 && sb.size() == 0)) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_done"}, 64'(n < limit), 64'd1);
    endtask

    task automatic wait_resp_valid(input string tag, input int limit);
        int n = 0;
        while (n < limit && !bus.resp_valid) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq({tag, "_valid_seen"}, 64'(bus.resp_valid), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int  exp_ids[6];
        logic [63:0] held_sum;
        int          held_id;
        exp_ids = '{0, 1, 2, 3, 0, 1};

        bus.resp_ready = 1'b1;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_resp_sum", bus.resp_sum, 64'd0);
        check_eq("rst_resp_cout", 64'(bus.resp_cout), 64'd0);
        check_eq("rst_resp_id", 64'(bus.resp_id), 64'd0);
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        mon_on = 1'b1;
        rst    = 1'b0;

        opq[1].push_back('{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0});
        wait_idle("single_add", 20);
        check_eq("single_add_sum", last.sum, 64'h0000_0001_0000_0000);
        check_eq("single_add_cout", 64'(last.cout), 64'd0);
        check_eq("single_add_id", 64'(last.id), 64'd1);

        opq[2].push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0});
        wait_idle("overflow", 20);
        check_eq("overflow_sum", last.sum, 64'd0);
        check_eq("overflow_cout", 64'(last.cout), 64'd1);

        opq[0].push_back('{64'd5, 64'd3, 1'b1});
        wait_idle("sub_pos", 20);
        check_eq("sub_pos_sum", last.sum, 64'd2);
        check_eq("sub_pos_cout", 64'(last.cout), 64'd1);

        opq[3].push_back('{64'd3, 64'd5, 1'b1});
        wait_idle("sub_neg", 20);
        check_eq("sub_neg_sum", last.sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("sub_neg_cout", 64'(last.cout), 64'd0);

        // Fairness and wrap from reset: all four held valid.
        do_reset();
        id_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) opq[i].push_back(rand_op());
        wait_idle("fair", 40);
        check_eq("fair_len", 64'(id_log.size()), 64'd8);
        for (int j = 0; j < 6; j++) check_eq("fair_order", 64'(id_log[j]), 64'(exp_ids[j]));

        // Backpressure: stall five cycles, then drain and refill with no bubble.
        bus.resp_ready = 1'b0;
        opq[0].push_back(rand_op());
        opq[1].push_back(rand_op());
        wait_resp_valid("bp", 20);
        held_sum = bus.resp_sum;
        held_id  = int'(bus.resp_id);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #2;
            check_eq("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
            check_eq("bp_hold_sum", bus.resp_sum, held_sum);
            check_eq("bp_hold_id", 64'(bus.resp_id), 64'(held_id));
            check_eq("bp_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        #1;
        check_eq("bp_refill_ready", 64'(bus.req_ready), 64'b0010);
        @(posedge clk);
        #2;
        check_eq("bp_no_bubble_valid", 64'(bus.resp_valid), 64'd1);
        check_eq("bp_no_bubble_id", 64'(bus.resp_id), 64'd1);
        wait_idle("bp", 20);

        // Mixed priority: pointer parked at 2, requesters 0 and 3 compete.
        do_reset();
        opq[1].push_back(rand_op());
        wait_idle("mix_setup", 20);
        id_log.delete();
        opq[0].push_back(rand_op());
        opq[3].push_back(rand_op());
        wait_idle("mix", 20);
        check_eq("mix_first", 64'(id_log[0]), 64'd3);
        check_eq("mix_second", 64'(id_log[1]), 64'd0);

        // Reset mid-operation with a stalled result and pending requesters.
        bus.resp_ready = 1'b0;
        id_log.delete();
        opq[0].push_back(rand_op());
        opq[2].push_back(rand_op());
        opq[3].push_back(rand_op());
        wait_resp_valid("midrst", 20);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("midrst_restart", 64'(bus.req_ready), 64'b0001);
        wait_idle("midrst", 20);
        check_eq("midrst_pre", 64'(id_log[0]), 64'd2);
        check_eq("midrst_post0", 64'(id_log[1]), 64'd0);
        check_eq("midrst_post1", 64'(id_log[2]), 64'd3);

        // Random traffic under random backpressure.
        for (int i = 0; i < NUM_REQ; i++)
            for (int r = 0; r < 6; r++) opq[i].push_back(rand_op());
        for (int j = 0; j < 60; j++) begin
            @(posedge clk);
            #1 bus.resp_ready = 1'($urandom_range(0, 3) != 0);
        end
        bus.resp_ready = 1'b1;
        wait_idle("random", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end
endmodule
